div_iter: RTL
=============

Name: div_iter

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU in the execute stage of the 5-stage MIPS pipeline.
- Consumes E-stage operands and produces the 64-bit {HI=remainder, LO=quotient} written through the HI/LO path.
- Drives div_stallE into the hazard unit, which freezes F/D/E/M/W while a division is in flight.

Parameters:
WIDTH, 32, operand width; quotient and remainder are WIDTH bits each, result is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start_i  input  1  E-stage instruction is DIV/DIVU (level; held high while stalled)
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
annul_i  input  1  cancel in-flight division (exception/flush); overrides start_i
opdata1_i  input  WIDTH  dividend (rs value after forwarding)
opdata2_i  input  WIDTH  divisor (rt value after forwarding)
result_o  output  2*WIDTH  {remainder, quotient}
ready_o  output  1  result_o valid this cycle
stall_o  output  1  to hazard unit as div_stallE

Behaviour:
- Reset (resetn=0, async): state=IDLE, cnt=0, result_o=0, ready_o=0, internal regs=0. Reset mid-division discards the operation; no ready_o follows.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - start_i & ~annul_i & opdata2_i==0 -> BY_ZERO.
  - start_i & ~annul_i & opdata2_i!=0 -> ON. Latch |dividend| and |divisor| (absolute values only when signed_i=1), the sign flags and signed_i; cnt=0.
- BY_ZERO: one cycle; quotient=0, remainder=0 -> END.
- ON: one iteration per cycle.
  - trial = {partial[WIDTH-1:0], next dividend MSB} - {1'b0, divisor}, computed in WIDTH+1 bits.
  - If trial >= 0: partial=trial and shift 1 into the quotient; otherwise shift in the bit without subtracting and shift 0 into the quotient.
  - cnt increments; when cnt==WIDTH-1 completes -> END.
- END:
  - Apply sign fix: negate quotient if dividend sign != divisor sign; remainder takes the dividend sign.
  - Register result_o; ready_o=1 for exactly this cycle.
  - Next cycle -> IDLE regardless of start_i.
- stall_o (combinational) = (state==IDLE & start_i & ~annul_i) | state==ON | state==BY_ZERO.
  - Low in END so the instruction leaves E on that edge and is not restarted.
- Latency: start seen in cycle 0; stall_o high cycles 0..WIDTH (WIDTH+1 cycles); ready_o in cycle WIDTH+1. Divide-by-zero: stall cycles 0..1, ready_o in cycle 2.
- Operand changes on opdata*_i and signed_i after the start cycle are ignored.
- annul_i=1 in any state: next state IDLE, no ready_o, stall_o=0 in the same cycle; result_o retains its previous value.
- Overflow 0x80000000 / 0xFFFFFFFF signed wraps: quotient=0x80000000, remainder=0. No trap.
- result_o holds its last value until the next END; ready_o is 0 outside END.
- Back-to-back divides: a new start_i in the cycle after END (IDLE) begins immediately.

Test Plan:
- DIVU 100/7: start at cycle 0 -> stall_o=1 cycles 0..32, ready_o=1 at cycle 33, result_o=0x00000002_0000000E, stall_o=0 at cycle 33.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3); DIV 7/-2 -> 0x00000001_FFFFFFFD.
- DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- Divide by zero, opdata2_i=0 -> stall_o high 2 cycles, ready_o at cycle 2, result_o=0.
- annul_i pulsed at cycle 10 of a divide -> stall_o=0 in the same cycle, no ready_o, state IDLE. A new DIVU 9/3 starting at cycle 12 gives result_o=0x00000000_00000003 at cycle 45.
- resetn low at cycle 5 of a divide -> stall_o, ready_o, result_o=0 immediately. Release with start_i held -> fresh division, correct result WIDTH+1 cycles later.

Source files
------------

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider for DIV / DIVU in the
// execute stage. One quotient bit is produced per clock. The 2*WIDTH-bit
// result is {remainder, quotient} and goes to the HI/LO path. stall_o feeds
// the hazard unit (div_stallE) and freezes the pipeline while a division is
// in flight.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start_i    E-stage instruction is DIV/DIVU (level, held while stalled)
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   annul_i    cancel any in-flight division; overrides start_i
//   opdata1_i  dividend
//   opdata2_i  divisor
//   result_o   {remainder, quotient}, holds until the next completion
//   ready_o    result_o is fresh this cycle (END state only)
//   stall_o    hold the pipeline while the division is running
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t stateReg, stateNext;

    logic [CNT_W-1:0] cntReg;
    // Holds |dividend| at start; each iteration shifts its MSB out into the
    // partial remainder and shifts the new quotient bit in at the LSB, so
    // after WIDTH steps it contains the unsigned quotient.
    logic [WIDTH-1:0] dividendReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] partialReg;
    logic             negQuotReg;
    logic             negRemReg;

    // Operand preparation for the start cycle
    logic             dividendNeg, divisorNeg, divByZero;
    logic [WIDTH-1:0] absDividend, absDivisor;

    // One restoring iteration
    logic [WIDTH:0]   shifted, trial;
    logic             qBit, lastIter;
    logic [WIDTH-1:0] partialStep, quotStep;
    logic [WIDTH-1:0] quotFinal, remFinal;

    always_comb begin
        dividendNeg = signed_i & opdata1_i[WIDTH-1];
        divisorNeg  = signed_i & opdata2_i[WIDTH-1];
        absDividend = dividendNeg ? (~opdata1_i + 1'b1) : opdata1_i;
        absDivisor  = divisorNeg  ? (~opdata2_i + 1'b1) : opdata2_i;
        divByZero   = (opdata2_i == '0);
    end

    always_comb begin
        shifted = {partialReg, dividendReg[WIDTH-1]};
        trial   = shifted - {1'b0, divisorReg};
        // partial < divisor always holds, so a non-negative trial is below
        // 2^WIDTH and bit WIDTH is an exact sign bit.
        qBit        = ~trial[WIDTH];
        partialStep = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quotStep    = {dividendReg[WIDTH-2:0], qBit};
        lastIter    = (cntReg == CNT_W'(WIDTH - 1));
        // Quotient is negative when operand signs differ; the remainder
        // follows the dividend. 0x80..0 / -1 falls out as 0x80..0 naturally.
        quotFinal   = negQuotReg ? (~quotStep + 1'b1)    : quotStep;
        remFinal    = negRemReg  ? (~partialStep + 1'b1) : partialStep;
    end

    // Next state and stall
    always_comb begin
        stateNext = stateReg;
        stall_o   = 1'b0;
        if (annul_i) begin
            stateNext = IDLE;
        end else begin
            unique case (stateReg)
                IDLE: begin
                    if (start_i) begin
                        stall_o   = 1'b1;
                        stateNext = divByZero ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    stall_o   = 1'b1;
                    stateNext = END;
                end
                ON: begin
                    stall_o = 1'b1;
                    if (lastIter) begin
                        stateNext = END;
                    end
                end
                END: begin
                    // Stall drops here so the instruction leaves E on this
                    // edge and is not restarted.
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
        // While reset is asserted the divider is idle; start_i may still be
        // high from the frozen E stage.
        if (!resetn) begin
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            dividendReg <= '0;
            divisorReg  <= '0;
            partialReg  <= '0;
            negQuotReg  <= 1'b0;
            negRemReg   <= 1'b0;
            result_o    <= '0;
            ready_o     <= 1'b0;
        end else begin
            stateReg <= stateNext;
            ready_o  <= 1'b0;
            if (!annul_i) begin
                unique case (stateReg)
                    IDLE: begin
                        if (start_i && !divByZero) begin
                            dividendReg <= absDividend;
                            divisorReg  <= absDivisor;
                            partialReg  <= '0;
                            cntReg      <= '0;
                            negQuotReg  <= dividendNeg ^ divisorNeg;
                            negRemReg   <= dividendNeg;
                        end
                    end
                    BY_ZERO: begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                    ON: begin
                        dividendReg <= quotStep;
                        partialReg  <= partialStep;
                        cntReg      <= cntReg + 1'b1;
                        // The result is registered on the edge into END so it
                        // is valid together with ready_o in that cycle.
                        if (lastIter) begin
                            result_o <= {remFinal, quotFinal};
                            ready_o  <= 1'b1;
                        end
                    end
                    END: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
